qa_write_credit_gate: RTL and testbench

QA_WRITE_CREDIT_GATE -- requirements
Module: qa_write_credit_gate

---
 rtl/qa_write_credit_gate.sv | 167 ++++++++++++++++
 tb/tb_qa_write_credit_gate.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qa_write_credit_gate.sv
// Buffers client writes and issues them to qa_driver under an outstanding-write
// credit ceiling; a fence drains buffered and in-flight writes before completing.
module qa_write_credit_gate #(
  parameter int CCI_ADDR_WIDTH  = 32,
  parameter int CCI_DATA_WIDTH  = 512,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CCI_ADDR_WIDTH-1:0]            wr_addr,
  input  logic [CCI_DATA_WIDTH-1:0]            wr_data,
  input  logic                                 wr_enable,
  output logic                                 wr_rdy,
  input  logic                                 fence_req,
  output logic                                 fence_rdy,
  output logic                                 fence_done,
  output logic [CCI_ADDR_WIDTH-1:0]            mem_write_addr,
  output logic [CCI_DATA_WIDTH-1:0]            mem_write_data,
  output logic                                 mem_write_enable,
  input  logic                                 mem_write_rdy,
  input  logic [1:0]                           mem_write_ack,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 ack_underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = OW + 1;

  localparam logic [CW-1:0] FIFO_FULL_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE_C   = PW'(1);
  localparam logic [OW-1:0] MAX_OUT_C   = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                      r_active;
  logic [CCI_ADDR_WIDTH-1:0] r_addr_mem [FIFO_DEPTH];
  logic [CCI_DATA_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;
  logic [CW-1:0]             w_count_next;
  logic [OW-1:0]             r_outstanding;
  logic [OW-1:0]             w_outstanding_next;
  logic                      r_ack_underflow;
  logic                      w_underflow_now;
  logic [SW-1:0]             w_credit_sum;
  logic [SW-1:0]             w_ack_ext;

  logic w_full;
  logic w_empty;
  logic w_in_run;
  logic w_enq;
  logic w_deq;
  logic w_fence_acc;

  // r_active holds the ready outputs low until the first edge after reset.
  assign w_full      = (r_count == FIFO_FULL_C);
  assign w_empty     = (r_count == {CW{1'b0}});
  assign w_in_run    = r_active && (r_state == RUN);
  assign w_enq       = wr_enable && !w_full && w_in_run;
  assign w_deq       = !w_empty && mem_write_rdy && (r_outstanding < MAX_OUT_C);
  assign w_fence_acc = fence_req && w_in_run;

  // Issue and ack fold into one credit update; excess acks clamp to zero.
  always_comb begin
    w_credit_sum       = {1'b0, r_outstanding} + {{OW{1'b0}}, w_deq};
    w_ack_ext          = SW'(mem_write_ack);
    w_underflow_now    = 1'b0;
    w_outstanding_next = r_outstanding;
    if (w_ack_ext > w_credit_sum) begin
      w_underflow_now    = 1'b1;
      w_outstanding_next = {OW{1'b0}};
    end else begin
      w_underflow_now    = 1'b0;
      w_outstanding_next = OW'(w_credit_sum - w_ack_ext);
    end
  end

  // FIFO occupancy after this cycle's enqueue and dequeue.
  always_comb begin
    w_count_next = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_next = r_count + CNT_ONE_C;
      2'b01:   w_count_next = r_count - CNT_ONE_C;
      default: w_count_next = r_count;
    endcase
  end

  // Fence sequencing: accept in RUN, wait for buffer and credits to empty, pulse done.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (w_fence_acc) begin
          w_state_next = DRAIN;
        end else begin
          w_state_next = RUN;
        end
      end
      DRAIN: begin
        if (w_empty && (w_outstanding_next == {OW{1'b0}})) begin
          w_state_next = DONE;
        end else begin
          w_state_next = DRAIN;
        end
      end
      DONE:    w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  // Control state, pointers, occupancy and credit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= RUN;
      r_active        <= 1'b0;
      r_wptr          <= {PW{1'b0}};
      r_rptr          <= {PW{1'b0}};
      r_count         <= {CW{1'b0}};
      r_outstanding   <= {OW{1'b0}};
      r_ack_underflow <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_active      <= 1'b1;
      r_count       <= w_count_next;
      r_outstanding <= w_outstanding_next;
      if (w_underflow_now) begin
        r_ack_underflow <= 1'b1;
      end
      if (w_enq) begin
        r_wptr <= r_wptr + PTR_ONE_C;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PTR_ONE_C;
      end
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr_mem[r_wptr] <= wr_addr;
      r_data_mem[r_wptr] <= wr_data;
    end
  end

  assign wr_rdy           = w_in_run && !w_full;
  assign fence_rdy        = w_in_run;
  assign fence_done       = (r_state == DONE);
  assign mem_write_enable = w_deq;
  assign mem_write_addr   = r_addr_mem[r_rptr];
  assign mem_write_data   = r_data_mem[r_rptr];
  assign outstanding      = r_outstanding;
  assign ack_underflow    = r_ack_underflow;

endmodule

// File: tb/tb_qa_write_credit_gate.sv
// Scenario bench for qa_write_credit_gate: issued writes are checked against a
// scoreboard queue filled when writes are driven.
module tb_qa_write_credit_gate;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int DEP  = 4;
  localparam int MAXO = 2;
  localparam int OW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_enable = 1'b0;
  logic          wr_rdy;
  logic          fence_req = 1'b0;
  logic          fence_rdy;
  logic          fence_done;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_enable;
  logic          mem_write_rdy = 1'b0;
  logic [1:0]    mem_write_ack = 2'd0;
  logic [OW-1:0] outstanding;
  logic          ack_underflow;

  int total = 0;
  int bad = 0;
  int n_issue = 0;
  logic [AW+DW-1:0] sb [$];

  always #5 clk = ~clk;

  qa_write_credit_gate #(
    .CCI_ADDR_WIDTH (AW),
    .CCI_DATA_WIDTH (DW),
    .FIFO_DEPTH     (DEP),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_enable       (wr_enable),
    .wr_rdy          (wr_rdy),
    .fence_req       (fence_req),
    .fence_rdy       (fence_rdy),
    .fence_done      (fence_done),
    .mem_write_addr  (mem_write_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_enable(mem_write_enable),
    .mem_write_rdy   (mem_write_rdy),
    .mem_write_ack   (mem_write_ack),
    .outstanding     (outstanding),
    .ack_underflow   (ack_underflow)
  );

  // Advance one cycle; at the falling edge any issued write is popped and compared.
  task automatic tick;
    logic [AW+DW-1:0] exp_v;
    @(negedge clk);
    if (reset === 1'b0 && mem_write_enable === 1'b1) begin
      n_issue++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got addr=%h data=%h, expected no issue", mem_write_addr, mem_write_data);
      end else begin
        exp_v = sb.pop_front();
        if ({mem_write_addr, mem_write_data} !== exp_v) begin
          bad++;
          $display("FAIL issue_order: got %h expected %h", {mem_write_addr, mem_write_data}, exp_v);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int idx, input logic expect_accept);
    wr_enable = 1'b1;
    wr_addr   = AW'(16'h1000 + idx);
    wr_data   = DW'(32'hA5A5_0000 + idx * 7);
    if (expect_accept) sb.push_back({wr_addr, wr_data});
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    total++; if (wr_rdy !== 1'b0) begin bad++; $display("FAIL rst_wr_rdy: got %b expected 0", wr_rdy); end
    total++; if (fence_rdy !== 1'b0) begin bad++; $display("FAIL rst_fence_rdy: got %b expected 0", fence_rdy); end
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL rst_mwe: got %b expected 0", mem_write_enable); end
    total++; if (fence_done !== 1'b0) begin bad++; $display("FAIL rst_fence_done: got %b expected 0", fence_done); end
    total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
    total++; if (ack_underflow !== 1'b0) begin bad++; $display("FAIL rst_underflow: got %b expected 0", ack_underflow); end
    tick;
    tick;
    reset = 1'b0;
    tick;
    total++; if (wr_rdy !== 1'b1) begin bad++; $display("FAIL post_rst_wr_rdy: got %b expected 1", wr_rdy); end
    total++; if (fence_rdy !== 1'b1) begin bad++; $display("FAIL post_rst_fence_rdy: got %b expected 1", fence_rdy); end
  endtask

  task automatic test_fill;
    int base;
    mem_write_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_wr(i, 1'b1);
      #1;
      total++; if (wr_rdy !== 1'b1) begin bad++; $display("FAIL fill_wr_rdy[%0d]: got %b expected 1", i, wr_rdy); end
      tick;
    end
    drive_wr(99, 1'b0);
    #1;
    total++; if (wr_rdy !== 1'b0) begin bad++; $display("FAIL fill_full: got %b expected 0", wr_rdy); end
    tick;
    wr_enable = 1'b0;
    #1;
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL fill_hold: got %b expected 0", mem_write_enable); end
    mem_write_rdy = 1'b1;
    base = n_issue;
    for (int k = 0; k < 4; k++) begin
      mem_write_ack = (k == 0) ? 2'd0 : 2'd1;
      #1;
      total++; if (mem_write_enable !== 1'b1) begin bad++; $display("FAIL fill_issue[%0d]: got %b expected 1", k, mem_write_enable); end
      tick;
    end
    mem_write_ack = 2'd1;
    #1;
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL fill_empty: got %b expected 0", mem_write_enable); end
    total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL fill_outstanding: got %0d expected 1", outstanding); end
    tick;
    mem_write_ack = 2'd0;
    #1;
    total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL fill_retired: got %0d expected 0", outstanding); end
    total++; if (n_issue - base !== 4) begin bad++; $display("FAIL fill_count: got %0d expected 4", n_issue - base); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL fill_sb_left: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_credit;
    int base;
    base = n_issue;
    mem_write_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_wr(10 + c, 1'b1);
      #1;
      total++; if (mem_write_enable !== (c != 0)) begin bad++; $display("FAIL credit_issue[%0d]: got %b expected %b", c, mem_write_enable, (c != 0)); end
      tick;
    end
    wr_enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL credit_block[%0d]: got %b expected 0", c, mem_write_enable); end
      tick;
    end
    total++; if (outstanding !== 2'd2) begin bad++; $display("FAIL credit_full: got %0d expected 2", outstanding); end
    total++; if (n_issue - base !== 2) begin bad++; $display("FAIL credit_count2: got %0d expected 2", n_issue - base); end
    mem_write_ack = 2'd1;
    #1;
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL credit_ack_cycle: got %b expected 0", mem_write_enable); end
    tick;
    mem_write_ack = 2'd0;
    #1;
    total++; if (mem_write_enable !== 1'b1) begin bad++; $display("FAIL credit_resume: got %b expected 1", mem_write_enable); end
    tick;
    total++; if (outstanding !== 2'd2) begin bad++; $display("FAIL credit_refill: got %0d expected 2", outstanding); end
    total++; if (n_issue - base !== 3) begin bad++; $display("FAIL credit_count3: got %0d expected 3", n_issue - base); end
  endtask

  task automatic test_ack_same_cycle;
    drive_wr(20, 1'b1);
    mem_write_ack = 2'd1;
    #1;
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL same_latency: got %b expected 0", mem_write_enable); end
    tick;
    wr_enable = 1'b0;
    mem_write_ack = 2'd2;
    #1;
    total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL same_pre: got %0d expected 1", outstanding); end
    total++; if (mem_write_enable !== 1'b1) begin bad++; $display("FAIL same_issue: got %b expected 1", mem_write_enable); end
    tick;
    mem_write_ack = 2'd0;
    #1;
    total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL same_outstanding: got %0d expected 0", outstanding); end
    total++; if (ack_underflow !== 1'b0) begin bad++; $display("FAIL same_underflow: got %b expected 0", ack_underflow); end
  endtask

  task automatic test_fence_empty;
    fence_req = 1'b1;
    #1;
    total++; if (fence_rdy !== 1'b1) begin bad++; $display("FAIL fe_rdy: got %b expected 1", fence_rdy); end
    tick;
    fence_req = 1'b0;
    #1;
    total++; if (fence_rdy !== 1'b0) begin bad++; $display("FAIL fe_drain_rdy: got %b expected 0", fence_rdy); end
    total++; if (wr_rdy !== 1'b0) begin bad++; $display("FAIL fe_drain_wr_rdy: got %b expected 0", wr_rdy); end
    total++; if (fence_done !== 1'b0) begin bad++; $display("FAIL fe_early_done: got %b expected 0", fence_done); end
    tick;
    #1;
    total++; if (fence_done !== 1'b1) begin bad++; $display("FAIL fe_done: got %b expected 1", fence_done); end
    total++; if (wr_rdy !== 1'b0) begin bad++; $display("FAIL fe_done_wr_rdy: got %b expected 0", wr_rdy); end
    tick;
    #1;
    total++; if (fence_done !== 1'b0) begin bad++; $display("FAIL fe_done_width: got %b expected 0", fence_done); end
    total++; if (fence_rdy !== 1'b1) begin bad++; $display("FAIL fe_back_run: got %b expected 1", fence_rdy); end
  endtask

  task automatic test_fence_drain;
    int base;
    logic exp_b;
    base = n_issue;
    mem_write_rdy = 1'b1;
    drive_wr(30, 1'b1);
    #1;
    tick;
    drive_wr(31, 1'b1);
    fence_req = 1'b1;
    #1;
    total++; if (wr_rdy !== 1'b1) begin bad++; $display("FAIL fd_same_wr_rdy: got %b expected 1", wr_rdy); end
    total++; if (fence_rdy !== 1'b1) begin bad++; $display("FAIL fd_same_fence_rdy: got %b expected 1", fence_rdy); end
    tick;
    wr_enable = 1'b0;
    fence_req = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      mem_write_ack = (c == 3 || c == 5) ? 2'd1 : 2'd0;
      #1;
      exp_b = (c == 7);
      total++; if (wr_rdy !== exp_b) begin bad++; $display("FAIL fd_wr_rdy[%0d]: got %b expected %b", c, wr_rdy, exp_b); end
      exp_b = (c == 6);
      total++; if (fence_done !== exp_b) begin bad++; $display("FAIL fd_done[%0d]: got %b expected %b", c, fence_done, exp_b); end
      exp_b = (c == 2);
      total++; if (mem_write_enable !== exp_b) begin bad++; $display("FAIL fd_issue[%0d]: got %b expected %b", c, mem_write_enable, exp_b); end
      tick;
    end
    mem_write_ack = 2'd0;
    total++; if (n_issue - base !== 2) begin bad++; $display("FAIL fd_count: got %0d expected 2", n_issue - base); end
    total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL fd_outstanding: got %0d expected 0", outstanding); end
  endtask

  task automatic test_underflow;
    mem_write_ack = 2'd1;
    #1;
    tick;
    mem_write_ack = 2'd0;
    #1;
    total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL uf_clamp: got %0d expected 0", outstanding); end
    total++; if (ack_underflow !== 1'b1) begin bad++; $display("FAIL uf_set: got %b expected 1", ack_underflow); end
    for (int c = 0; c < 3; c++) begin
      tick;
      total++; if (ack_underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky[%0d]: got %b expected 1", c, ack_underflow); end
    end
  endtask

  task automatic test_reset_mid;
    mem_write_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_wr(40 + i, 1'b1);
      fence_req = (i == 2);
      #1;
      total++; if (wr_rdy !== 1'b1) begin bad++; $display("FAIL rm_wr_rdy[%0d]: got %b expected 1", i, wr_rdy); end
      tick;
    end
    wr_enable = 1'b0;
    fence_req = 1'b0;
    #1;
    total++; if (fence_rdy !== 1'b0) begin bad++; $display("FAIL rm_in_drain: got %b expected 0", fence_rdy); end
    reset = 1'b1;
    mem_write_rdy = 1'b1;
    sb.delete();
    #1;
    total++; if (wr_rdy !== 1'b0) begin bad++; $display("FAIL rm_wr_rdy: got %b expected 0", wr_rdy); end
    total++; if (fence_rdy !== 1'b0) begin bad++; $display("FAIL rm_fence_rdy: got %b expected 0", fence_rdy); end
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL rm_mwe: got %b expected 0", mem_write_enable); end
    total++; if (fence_done !== 1'b0) begin bad++; $display("FAIL rm_fence_done: got %b expected 0", fence_done); end
    total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL rm_outstanding: got %0d expected 0", outstanding); end
    total++; if (ack_underflow !== 1'b0) begin bad++; $display("FAIL rm_underflow: got %b expected 0", ack_underflow); end
    tick;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL rm_no_issue[%0d]: got %b expected 0", c, mem_write_enable); end
      total++; if (fence_done !== 1'b0) begin bad++; $display("FAIL rm_no_done[%0d]: got %b expected 0", c, fence_done); end
      tick;
    end
    total++; if (wr_rdy !== 1'b1) begin bad++; $display("FAIL rm_resume: got %b expected 1", wr_rdy); end
    mem_write_ack = 2'd1;
    #1;
    tick;
    mem_write_ack = 2'd0;
    #1;
    total++; if (ack_underflow !== 1'b1) begin bad++; $display("FAIL rm_late_ack: got %b expected 1", ack_underflow); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_credit();
    test_ack_same_cycle();
    test_fence_empty();
    test_fence_drain();
    test_underflow();
    test_reset_mid();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
